// File: rtl/seg7_pkg.sv
// Shared constants and font for the seven-segment scan driver.
// Contents:
//   IDX_W, NUM_DIGITS - digit index width and digit count
//   SEG_OFF, AN_OFF   - all-dark segment / anode patterns (active-low)
//   hex_to_seg()      - hex nibble to {g,f,e,d,c,b,a}, active-low
package seg7_pkg;

    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        unique case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   hex - 4-bit digit value
//   seg - segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with a
// double-buffered input: loads land in a pending buffer and are committed to
// the active buffer only at frame boundaries.
// Ports:
//   clock, reset          - system clock (posedge), async active-high reset
//   load                  - strobe: capture digits/dp_in/blank_in as pending
//   digits, dp_in, blank_in - 4 hex digits ([3:0] rightmost), dp and blank masks
//   pending               - pending buffer holds uncommitted data
//   frame_done            - one-cycle pulse on the frame-boundary cycle
//   an, seg, dp           - registered display pins, all active-low
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic        pending,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick, boundary;

    logic [15:0] pend_digits_q, act_digits_q;
    logic [3:0]  pend_dp_q, act_dp_q;
    logic [3:0]  pend_blank_q, act_blank_q;
    logic        pending_q, pending_d;

    logic [3:0]  cur_hex;
    logic [6:0]  cur_seg;
    logic        lit;
    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    assign tick     = (count_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        count_d   = tick ? '0 : count_q + 1'b1;
        idx_d     = tick ? idx_q + 1'b1 : idx_q;
        // A load in the boundary cycle re-arms pending after the commit.
        pending_d = pending_q;
        if (boundary) pending_d = 1'b0;
        if (load)     pending_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= AN_OFF;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= 4'b1111;
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            if (boundary && pending_q) begin
                act_digits_q <= pend_digits_q;
                act_dp_q     <= pend_dp_q;
                act_blank_q  <= pend_blank_q;
            end
            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp_in;
                pend_blank_q  <= blank_in;
            end
        end
    end

    assign cur_hex = act_digits_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    always_comb begin
        lit   = (count_q >= CNT_GUARD) && !act_blank_q[idx_q];
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = cur_seg;
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYCLES=2).
// The model tracks cycles since reset and derives slot/digit with arithmetic.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        pending, frame_done, dp;
    logic [3:0]  an;
    logic [6:0]  seg;

    seg7_scan_driver #(
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .pending    (pending),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pending;
        logic       frame_done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [6:0] font_tbl [16];
    initial begin
        font_tbl[0]  = 7'b1000000; font_tbl[1]  = 7'b1111001;
        font_tbl[2]  = 7'b0100100; font_tbl[3]  = 7'b0110000;
        font_tbl[4]  = 7'b0011001; font_tbl[5]  = 7'b0010010;
        font_tbl[6]  = 7'b0000010; font_tbl[7]  = 7'b1111000;
        font_tbl[8]  = 7'b0000000; font_tbl[9]  = 7'b0010000;
        font_tbl[10] = 7'b0001000; font_tbl[11] = 7'b0000011;
        font_tbl[12] = 7'b1000110; font_tbl[13] = 7'b0100001;
        font_tbl[14] = 7'b0000110; font_tbl[15] = 7'b0001110;
    end

    // Reference model state
    int          t = 0;
    logic [15:0] m_act = '0, m_pbuf = '0;
    logic [3:0]  m_act_dp = '0, m_pbuf_dp = '0;
    logic [3:0]  m_act_bl = 4'hF, m_pbuf_bl = 4'hF;
    logic        m_pend = 1'b0;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            t = 0; m_act = '0; m_act_dp = '0; m_act_bl = 4'hF; m_pend = 1'b0;
            sb.delete();
        end else begin
            exp_t       e;
            int         pos, d;
            logic       lit;
            logic [3:0] oh;
            pos = t % DIV;
            d   = (t / DIV) % 4;
            lit = (pos >= BLANK) && !m_act_bl[d];
            oh  = 4'b0001 << d;
            e.an  = lit ? ~oh : 4'b1111;
            e.seg = lit ? font_tbl[m_act[d*4 +: 4]] : 7'b1111111;
            e.dp  = lit ? ~m_act_dp[d] : 1'b1;
            if ((t % FRAME == FRAME - 1) && m_pend) begin
                m_act = m_pbuf; m_act_dp = m_pbuf_dp; m_act_bl = m_pbuf_bl;
                m_pend = 1'b0;
            end
            if (load) begin
                m_pbuf = digits; m_pbuf_dp = dp_in; m_pbuf_bl = blank_in;
                m_pend = 1'b1;
            end
            t++;
            e.pending    = m_pend;
            e.frame_done = (t % FRAME == FRAME - 1);
            sb.push_back(e);
        end
    end

    // Monitor: compares every registered cycle against the scoreboard.
    initial forever begin
        @(negedge clock);
        if (!reset && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({an, seg, dp, pending, frame_done} !==
                {e.an, e.seg, e.dp, e.pending, e.frame_done}) begin
                failures++;
                $display("FAIL cycle t=%0d: got an=%b seg=%b dp=%b pend=%b fd=%b, want an=%b seg=%b dp=%b pend=%b fd=%b",
                         t, an, seg, dp, pending, frame_done,
                         e.an, e.seg, e.dp, e.pending, e.frame_done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_dark(input string name);
        chk({name, " an"},  32'(an),  32'h0000000F);
        chk({name, " seg"}, 32'(seg), 32'h0000007F);
        chk({name, " dp"},  32'(dp),  32'h1);
        chk({name, " pending"}, 32'(pending), 32'h0);
        chk({name, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
        load = 1'b1; digits = dg; dp_in = dpv; blank_in = bl;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (!frame_done && n < 4 * FRAME) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!frame_done) begin
            failures++;
            $display("FAIL wait_frame_done: got no pulse within %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state, then dark frames
        repeat (3) @(negedge clock);
        chk_dark("reset");
        reset = 1'b0;
        repeat (70) @(negedge clock);

        // 2: 1234 all digits visible
        do_load(16'h1234, 4'b0000, 4'b0000);
        wait_fd();
        repeat (2 * FRAME) @(negedge clock);

        // 3: last load wins within a frame
        wait_fd();
        @(negedge clock);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        repeat (3) @(negedge clock);
        do_load(16'hF0F0, 4'b0000, 4'b0000);
        repeat (2 * FRAME + 6) @(negedge clock);

        // 4: dp and blank masks
        do_load(16'h8888, 4'b0101, 4'b1000);
        repeat (2 * FRAME + 6) @(negedge clock);

        // 5: load in the boundary cycle while 1111 is pending
        wait_fd();
        @(negedge clock);
        do_load(16'h1111, 4'b0000, 4'b0000);
        wait_fd();
        do_load(16'h5555, 4'b0000, 4'b0000);
        chk("pending after boundary load", 32'(pending), 32'h1);
        repeat (2 * FRAME + 6) @(negedge clock);

        // 6: async reset mid-slot 2 while displaying
        wait_fd();
        repeat (2 * DIV + 4) @(negedge clock);
        chk("lit before reset", 32'(an), 32'h0000000B);
        #2 reset = 1'b1;
        #1 chk_dark("mid-slot reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);

        // Random loads
        for (int i = 0; i < 25; i++) begin
            do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
            repeat ($urandom_range(0, 40)) @(negedge clock);
        end
        repeat (2 * FRAME + 6) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
